// File: rtl/tlb_lru_param_if.sv
// CPU request/response and page-table handshake bundle for tlb_lru_param.
// The TLB takes the slave side; the CPU/page-table environment takes the master side.
interface tlb_lru_param_if #(
    parameter int VA_WIDTH    = 14,
    parameter int OFFSET_BITS = 8,
    parameter int PPN_WIDTH   = 2
);
    localparam int V = VA_WIDTH - OFFSET_BITS;
    localparam int P = PPN_WIDTH + OFFSET_BITS;

    logic                 req_valid;
    logic                 req_ready;
    logic [VA_WIDTH-1:0]  req_vaddr;
    logic                 req_write;
    logic                 flush;
    logic                 resp_valid;
    logic [P-1:0]         resp_paddr;
    logic                 resp_write;
    logic                 resp_fault;
    logic                 pt_req_valid;
    logic                 pt_req_write;
    logic [V-1:0]         pt_req_vpn;
    logic [PPN_WIDTH-1:0] pt_wb_ppn;
    logic                 pt_wb_dirty;
    logic                 pt_wb_reference;
    logic                 pt_done;
    logic [PPN_WIDTH-1:0] pt_ppn;
    logic                 pt_fault;
    logic                 pt_dirty;
    logic                 pt_reference;

    modport master (
        output req_valid, req_vaddr, req_write, flush,
        output pt_done, pt_ppn, pt_fault, pt_dirty, pt_reference,
        input  req_ready, resp_valid, resp_paddr, resp_write, resp_fault,
        input  pt_req_valid, pt_req_write, pt_req_vpn, pt_wb_ppn, pt_wb_dirty, pt_wb_reference
    );

    modport slave (
        input  req_valid, req_vaddr, req_write, flush,
        input  pt_done, pt_ppn, pt_fault, pt_dirty, pt_reference,
        output req_ready, resp_valid, resp_paddr, resp_write, resp_fault,
        output pt_req_valid, pt_req_write, pt_req_vpn, pt_wb_ppn, pt_wb_dirty, pt_wb_reference
    );
endinterface

// File: rtl/tlb_lru_param.sv
// Fully-associative TLB with true-LRU replacement, dirty write-back and page-table fill.
// Each slot keeps its own state and rank; the top sequences lookup, write-back and fill.
module tlb_lru_param_slot #(
    parameter int V         = 6,
    parameter int PPN_WIDTH = 2,
    parameter int R         = 2,
    parameter int INIT_RANK = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [V-1:0]         lookup_tag,
    input  logic                 sel,
    input  logic                 touch,
    input  logic [R-1:0]         touch_rank,
    input  logic                 install,
    input  logic [V-1:0]         new_tag,
    input  logic [PPN_WIDTH-1:0] new_ppn,
    input  logic                 new_dirty,
    input  logic                 mark_ref,
    input  logic                 mark_dirty,
    input  logic                 clean,
    output logic                 hit,
    output logic                 valid,
    output logic [V-1:0]         tag,
    output logic [PPN_WIDTH-1:0] ppn,
    output logic                 dirty,
    output logic                 reference,
    output logic [R-1:0]         rank
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid     <= 1'b0;
            dirty     <= 1'b0;
            reference <= 1'b0;
            rank      <= R'(INIT_RANK);
        end else begin
            // Everything more recent than the touched slot ages by one, keeping ranks a permutation.
            if (touch) begin
                if (sel)
                    rank <= '0;
                else if (rank < touch_rank)
                    rank <= rank + 1'b1;
            end
            if (sel && install) begin
                valid     <= 1'b1;
                tag       <= new_tag;
                ppn       <= new_ppn;
                dirty     <= new_dirty;
                reference <= 1'b1;
            end
            if (sel && mark_ref)
                reference <= 1'b1;
            if (sel && mark_dirty)
                dirty <= 1'b1;
            if (sel && clean)
                dirty <= 1'b0;
        end
    end

    assign hit = valid && (tag == lookup_tag);
endmodule

module tlb_lru_param #(
    parameter int ENTRY_COUNT = 4,
    parameter int VA_WIDTH    = 14,
    parameter int OFFSET_BITS = 8,
    parameter int PPN_WIDTH   = 2
) (
    input logic            clk,
    input logic            reset,
    tlb_lru_param_if.slave tlb
);
    localparam int R = $clog2(ENTRY_COUNT);
    localparam int V = VA_WIDTH - OFFSET_BITS;
    localparam int P = PPN_WIDTH + OFFSET_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

    state_t                                state;
    logic [VA_WIDTH-1:0]                   vaddr;
    logic                                  write;
    logic [R-1:0]                          victim;

    logic                                  req_ready;
    logic                                  resp_valid;
    logic [P-1:0]                          resp_paddr;
    logic                                  resp_write;
    logic                                  resp_fault;
    logic                                  pt_req_valid;
    logic                                  pt_req_write;
    logic [V-1:0]                          pt_req_vpn;
    logic [PPN_WIDTH-1:0]                  pt_wb_ppn;
    logic                                  pt_wb_dirty;
    logic                                  pt_wb_reference;

    logic [ENTRY_COUNT-1:0]                hit_vec;
    logic [ENTRY_COUNT-1:0]                valid;
    logic [ENTRY_COUNT-1:0]                dirty;
    logic [ENTRY_COUNT-1:0]                reference;
    logic [ENTRY_COUNT-1:0][V-1:0]         tag;
    logic [ENTRY_COUNT-1:0][PPN_WIDTH-1:0] ppn;
    logic [ENTRY_COUNT-1:0][R-1:0]         rank;

    logic                                  hit;
    logic [R-1:0]                          hit_idx;
    logic                                  free;
    logic [R-1:0]                          free_idx;
    logic [R-1:0]                          lru_idx;
    logic [R-1:0]                          pick;
    logic [R-1:0]                          target;
    logic [R-1:0]                          touch_rank;
    logic                                  clear;
    logic                                  touch;
    logic                                  install;
    logic                                  mark_ref;
    logic                                  mark_dirty;
    logic                                  clean;

    logic [V-1:0]                          vpn;
    logic [OFFSET_BITS-1:0]                offset;
    logic                                  unused_pt_reference;

    assign vpn                 = vaddr[VA_WIDTH-1:OFFSET_BITS];
    assign offset              = vaddr[OFFSET_BITS-1:0];
    assign unused_pt_reference = tlb.pt_reference;

    for (genvar i = 0; i < ENTRY_COUNT; i++) begin : g_slot
        tlb_lru_param_slot #(
            .V(V), .PPN_WIDTH(PPN_WIDTH), .R(R), .INIT_RANK(ENTRY_COUNT - 1 - i)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .lookup_tag (vpn),
            .sel        (target == R'(i)),
            .touch      (touch),
            .touch_rank (touch_rank),
            .install    (install),
            .new_tag    (vpn),
            .new_ppn    (tlb.pt_ppn),
            .new_dirty  (tlb.pt_dirty | write),
            .mark_ref   (mark_ref),
            .mark_dirty (mark_dirty),
            .clean      (clean),
            .hit        (hit_vec[i]),
            .valid      (valid[i]),
            .tag        (tag[i]),
            .ppn        (ppn[i]),
            .dirty      (dirty[i]),
            .reference  (reference[i]),
            .rank       (rank[i])
        );
    end

    // Descending scans so the lowest index wins on ties.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        lru_idx  = '0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit     = 1'b1;
                hit_idx = R'(i);
            end
            if (!valid[i]) begin
                free     = 1'b1;
                free_idx = R'(i);
            end
            if (rank[i] == R'(ENTRY_COUNT - 1))
                lru_idx = R'(i);
        end
        pick = free ? free_idx : lru_idx;
    end

    always_comb begin
        clear      = 1'b0;
        touch      = 1'b0;
        install    = 1'b0;
        mark_ref   = 1'b0;
        mark_dirty = 1'b0;
        clean      = 1'b0;
        target     = victim;
        case (state)
            IDLE:   clear = tlb.flush;
            LOOKUP: if (hit) begin
                        touch      = 1'b1;
                        target     = hit_idx;
                        mark_ref   = 1'b1;
                        mark_dirty = write;
                    end
            WB:     clean = tlb.pt_done;
            FILL:   if (tlb.pt_done && !tlb.pt_fault) begin
                        install = 1'b1;
                        touch   = 1'b1;
                    end
            default: ;
        endcase
        touch_rank = rank[target];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            vaddr           <= '0;
            write           <= 1'b0;
            victim          <= '0;
            req_ready       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_paddr      <= '0;
            resp_write      <= 1'b0;
            resp_fault      <= 1'b0;
            pt_req_valid    <= 1'b0;
            pt_req_write    <= 1'b0;
            pt_req_vpn      <= '0;
            pt_wb_ppn       <= '0;
            pt_wb_dirty     <= 1'b0;
            pt_wb_reference <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (!tlb.flush && tlb.req_valid && req_ready) begin
                        vaddr     <= tlb.req_vaddr;
                        write     <= tlb.req_write;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid <= 1'b1;
                        resp_paddr <= {ppn[hit_idx], offset};
                        resp_write <= write;
                        resp_fault <= 1'b0;
                        state      <= RESP;
                    end else begin
                        victim       <= pick;
                        pt_req_valid <= 1'b1;
                        if (valid[pick] && dirty[pick]) begin
                            pt_req_write    <= 1'b1;
                            pt_req_vpn      <= tag[pick];
                            pt_wb_ppn       <= ppn[pick];
                            pt_wb_dirty     <= 1'b1;
                            pt_wb_reference <= reference[pick];
                            state           <= WB;
                        end else begin
                            pt_req_write <= 1'b0;
                            pt_req_vpn   <= vpn;
                            state        <= FILL;
                        end
                    end
                end
                WB: begin
                    // Flip straight into the fetch; pt_req_valid stays high across the change.
                    if (tlb.pt_done) begin
                        pt_req_write    <= 1'b0;
                        pt_req_vpn      <= vpn;
                        pt_wb_ppn       <= '0;
                        pt_wb_dirty     <= 1'b0;
                        pt_wb_reference <= 1'b0;
                        state           <= FILL;
                    end
                end
                FILL: begin
                    if (tlb.pt_done) begin
                        pt_req_valid <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_write   <= write;
                        resp_fault   <= tlb.pt_fault;
                        resp_paddr   <= tlb.pt_fault ? '0 : {tlb.pt_ppn, offset};
                        state        <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tlb.req_ready       = req_ready;
    assign tlb.resp_valid      = resp_valid;
    assign tlb.resp_paddr      = resp_paddr;
    assign tlb.resp_write      = resp_write;
    assign tlb.resp_fault      = resp_fault;
    assign tlb.pt_req_valid    = pt_req_valid;
    assign tlb.pt_req_write    = pt_req_write;
    assign tlb.pt_req_vpn      = pt_req_vpn;
    assign tlb.pt_wb_ppn       = pt_wb_ppn;
    assign tlb.pt_wb_dirty     = pt_wb_dirty;
    assign tlb.pt_wb_reference = pt_wb_reference;
endmodule

// File: tb/tb_tlb_lru_param.sv
`define CHK(tag, obs, exp) check(tag, 32'(obs), 32'(exp))

module tb_tlb_lru_param;
  localparam int N = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tlb_lru_param_if #(.VA_WIDTH(14), .OFFSET_BITS(8), .PPN_WIDTH(2)) tlb ();

  tlb_lru_param #(.ENTRY_COUNT(N), .VA_WIDTH(14), .OFFSET_BITS(8), .PPN_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .tlb   (tlb)
  );

  bit         m_valid[N];
  logic [5:0] m_tag[N];
  logic [1:0] m_ppn[N];
  bit         m_dirty[N];
  bit         m_ref[N];
  int         lru[$];

  logic [1:0] tab_ppn[64];
  bit         tab_fault[64];
  bit         tab_dirty[64];

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (tlb.resp_valid === 1'b1 && tlb.pt_req_valid !== 1'b0) begin
        errors++;
        $error("FAIL resp_valid with pt_req_valid high");
      end
      checks++;
      if (tlb.resp_valid === 1'b1 && tlb.req_ready !== 1'b0) begin
        errors++;
        $error("FAIL resp_valid with req_ready high");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_ref[i]   = 0;
    end
    lru.delete();
    for (int i = N - 1; i >= 0; i--) lru.push_back(i);
  endtask

  task automatic model_touch(input int s);
    for (int k = 0; k < lru.size(); k++)
      if (lru[k] == s) begin
        lru.delete(k);
        break;
      end
    lru.push_front(s);
  endtask

  task automatic check_state();
    logic [N-1:0]   ev;
    logic [N*R-1:0] er;
    for (int i = 0; i < N; i++) ev[i] = m_valid[i];
    er = '0;
    for (int k = 0; k < N; k++) er[lru[k]*R +: R] = R'(k);
    `CHK("slot_valid", dut.valid, ev);
    `CHK("slot_rank", dut.rank, er);
  endtask

  task automatic pt_phase(input logic [5:0] ev, input logic [1:0] p, input logic f, input logic dty);
    int dly = $urandom_range(0, 2);
    repeat (dly) begin
      @(negedge clk);
      `CHK("pt_hold_valid", tlb.pt_req_valid, 1);
      `CHK("pt_hold_vpn", tlb.pt_req_vpn, ev);
    end
    tlb.pt_done = 1; tlb.pt_ppn = p; tlb.pt_fault = f; tlb.pt_dirty = dty;
    tlb.pt_reference = 1'($urandom);
    @(negedge clk);
    tlb.pt_done = 0; tlb.pt_ppn = 2'($urandom); tlb.pt_fault = 1'($urandom);
    tlb.pt_dirty = 1'($urandom);
  endtask

  task automatic do_req(input logic [5:0] vpn, input logic [7:0] off, input logic wr);
    int         hs, vic;
    bit         wb, flt;
    logic [9:0] pa;
    `CHK("req_ready_idle", tlb.req_ready, 1);
    tlb.req_valid = 1; tlb.req_vaddr = {vpn, off}; tlb.req_write = wr;
    @(negedge clk);
    tlb.req_valid = 0; tlb.req_vaddr = 14'($urandom); tlb.req_write = 1'($urandom);
    tlb.flush = 1'($urandom);
    `CHK("req_ready_busy", tlb.req_ready, 0);
    hs = -1;
    for (int i = N - 1; i >= 0; i--) if (m_valid[i] && m_tag[i] == vpn) hs = i;
    if (hs >= 0) begin
      model_touch(hs);
      m_ref[hs] = 1;
      if (wr) m_dirty[hs] = 1;
      flt = 0;
      pa  = {m_ppn[hs], off};
      @(negedge clk);
      tlb.flush = 0;
    end else begin
      vic = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) vic = i;
      if (vic < 0) vic = lru[$];
      wb = m_valid[vic] && m_dirty[vic];
      @(negedge clk);
      tlb.flush = 0;
      `CHK("pt_req_valid", tlb.pt_req_valid, 1);
      `CHK("pt_req_write", tlb.pt_req_write, wb);
      if (wb) begin
        `CHK("wb_vpn", tlb.pt_req_vpn, m_tag[vic]);
        `CHK("wb_ppn", tlb.pt_wb_ppn, m_ppn[vic]);
        `CHK("wb_dirty", tlb.pt_wb_dirty, 1);
        `CHK("wb_reference", tlb.pt_wb_reference, m_ref[vic]);
        pt_phase(m_tag[vic], 2'($urandom), 1'($urandom), 1'($urandom));
        m_dirty[vic] = 0;
        `CHK("wb_to_fill_valid", tlb.pt_req_valid, 1);
        `CHK("wb_to_fill_write", tlb.pt_req_write, 0);
      end
      `CHK("fill_vpn", tlb.pt_req_vpn, vpn);
      flt = tab_fault[vpn];
      pt_phase(vpn, tab_ppn[vpn], flt, tab_dirty[vpn]);
      if (flt) pa = '0;
      else begin
        m_valid[vic] = 1; m_tag[vic] = vpn; m_ppn[vic] = tab_ppn[vpn];
        m_ref[vic] = 1; m_dirty[vic] = tab_dirty[vpn] | wr;
        model_touch(vic);
        pa = {tab_ppn[vpn], off};
      end
    end
    `CHK("resp_valid", tlb.resp_valid, 1);
    `CHK("resp_paddr", tlb.resp_paddr, pa);
    `CHK("resp_fault", tlb.resp_fault, flt);
    `CHK("resp_write", tlb.resp_write, wr);
    `CHK("pt_idle_at_resp", tlb.pt_req_valid, 0);
    @(negedge clk);
    `CHK("resp_pulse", tlb.resp_valid, 0);
    `CHK("req_ready_back", tlb.req_ready, 1);
    check_state();
  endtask

  task automatic flush_with_req();
    tlb.flush = 1; tlb.req_valid = 1; tlb.req_vaddr = 14'h0312; tlb.req_write = 1;
    @(negedge clk);
    tlb.flush = 0; tlb.req_valid = 0;
    model_clear();
    `CHK("flush_ready", tlb.req_ready, 1);
    `CHK("flush_no_resp", tlb.resp_valid, 0);
    check_state();
    @(negedge clk);
    `CHK("flush_no_resp2", tlb.resp_valid, 0);
    `CHK("flush_no_pt", tlb.pt_req_valid, 0);
  endtask

  task automatic reset_mid_fill(input logic [5:0] vpn);
    tlb.req_valid = 1; tlb.req_vaddr = {vpn, 8'h5a}; tlb.req_write = 0;
    @(negedge clk);
    tlb.req_valid = 0;
    @(negedge clk);
    `CHK("rst_fill_valid", tlb.pt_req_valid, 1);
    `CHK("rst_fill_write", tlb.pt_req_write, 0);
    reset = 1;
    @(negedge clk);
    model_clear();
    `CHK("rst_pt_drop", tlb.pt_req_valid, 0);
    `CHK("rst_no_resp", tlb.resp_valid, 0);
    `CHK("rst_ready_low", tlb.req_ready, 0);
    check_state();
    reset = 0;
    @(negedge clk);
    `CHK("rst_no_resp2", tlb.resp_valid, 0);
    `CHK("rst_ready_high", tlb.req_ready, 1);
  endtask

  initial begin
    reset = 1;
    tlb.req_valid = 0; tlb.req_vaddr = '0; tlb.req_write = 0; tlb.flush = 0;
    tlb.pt_done = 0; tlb.pt_ppn = '0; tlb.pt_fault = 0; tlb.pt_dirty = 0;
    tlb.pt_reference = 0;
    for (int v = 0; v < 64; v++) begin
      tab_ppn[v]   = 2'($urandom);
      tab_fault[v] = 0;
      tab_dirty[v] = (v >= 12) ? 1'($urandom) : 1'b0;
    end
    tab_ppn[3]    = 2'd2;
    tab_fault[9]  = 1;
    tab_fault[13] = 1;
    model_clear();

    @(negedge clk);
    @(negedge clk);
    `CHK("rst_req_ready", tlb.req_ready, 0);
    `CHK("rst_resp_valid", tlb.resp_valid, 0);
    `CHK("rst_resp_paddr", tlb.resp_paddr, 0);
    `CHK("rst_resp_fault", tlb.resp_fault, 0);
    `CHK("rst_pt_req_valid", tlb.pt_req_valid, 0);
    `CHK("rst_pt_req_vpn", tlb.pt_req_vpn, 0);
    `CHK("rst_pt_wb_dirty", tlb.pt_wb_dirty, 0);
    checks++;
    if (tlb.req_ready !== 1'b0) begin
      errors++;
      $error("FAIL req_ready not low in reset");
    end
    checks++;
    if (tlb.resp_write !== 1'b0) begin
      errors++;
      $error("FAIL resp_write not 0 in reset");
    end
    check_state();
    reset = 0;
    @(negedge clk);
    `CHK("ready_after_rst", tlb.req_ready, 1);
    checks++;
    if (tlb.req_ready !== 1'b1) begin
      errors++;
      $error("FAIL req_ready not high after reset");
    end

    do_req(6'd3, 8'h12, 0);
    do_req(6'd3, 8'h34, 0);

    flush_with_req();
    do_req(6'd3, 8'h12, 0);

    flush_with_req();
    do_req(6'd1, 8'h00, 0);
    do_req(6'd2, 8'h11, 0);
    do_req(6'd3, 8'h22, 0);
    do_req(6'd4, 8'h33, 0);
    do_req(6'd1, 8'h44, 0);
    do_req(6'd5, 8'h55, 0);

    do_req(6'd6, 8'h66, 1);
    do_req(6'd6, 8'h67, 1);
    do_req(6'd2, 8'h01, 0);
    do_req(6'd8, 8'h02, 0);
    do_req(6'd10, 8'h03, 0);
    do_req(6'd11, 8'h04, 0);

    do_req(6'd9, 8'h99, 0);
    do_req(6'd9, 8'h98, 1);

    for (int n = 0; n < 80; n++)
      do_req(6'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));

    flush_with_req();
    reset_mid_fill(6'd7);
    do_req(6'd7, 8'h77, 1);
    do_req(6'd7, 8'h78, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
